// File: rtl/fault_diagnoser_if.sv
// Sample/verdict bundle between a fault-diagnosis harness and fault_diagnoser.
// The err_count signal exists only when DIAG_ERRCNT_EN is defined.
interface fault_diagnoser_if #(
  parameter int W = 8
);
  localparam int LW = $clog2(W);

  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  exp_data;
  logic [W-1:0]  obs_data;
  logic          done;
  logic [LW-1:0] f_loc;
  logic [1:0]    f_type;
  logic          ambiguous;
`ifdef DIAG_ERRCNT_EN
  logic [7:0]    err_count;
`endif

  modport master (
    output start, in_valid, exp_data, obs_data,
    input  in_ready, done, f_loc, f_type, ambiguous
`ifdef DIAG_ERRCNT_EN
    , input err_count
`endif
  );

  modport slave (
    input  start, in_valid, exp_data, obs_data,
    output in_ready, done, f_loc, f_type, ambiguous
`ifdef DIAG_ERRCNT_EN
    , output err_count
`endif
  );
endinterface

// File: rtl/fault_diagnoser.sv
// Fault diagnoser: watches NSAMP (expected, observed) word pairs and decides
// which single bit was faulted and whether it was stuck-at-0, stuck-at-1 or
// flipping. f_type: 00 none, 01 stuck-at-0, 10 stuck-at-1, 11 bit-flip.
// Optional macro DIAG_ERRCNT_EN adds err_count, the saturating number of
// mismatching samples in the window.
module fault_diagnoser #(
  parameter int NSAMP = 16,
  parameter int W     = 8
) (
  input logic              clk,
  input logic              reset,
  fault_diagnoser_if.slave bus
);
  localparam int LW = $clog2(W);
  localparam int CW = $clog2(NSAMP + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  state_t        state;
  state_t        state_nxt;

  // Per-bit evidence gathered over the window
  logic [W-1:0]  diff;
  logic [W-1:0]  sa0_ok;
  logic [W-1:0]  sa1_ok;
  logic [W-1:0]  flip_ok;
  logic [W-1:0]  seen0;
  logic [W-1:0]  seen1;
  logic [CW-1:0] cnt;

  logic [LW-1:0] f_loc_r;
  logic [1:0]    f_type_r;
  logic          amb_r;
  logic [LW-1:0] loc_nxt;
  logic [1:0]    type_nxt;
  logic          amb_nxt;

  logic          accept;
  logic          last;
  logic          init;

  // Index of the set bit of a one-hot word
  function automatic logic [LW-1:0] bit_index(input logic [W-1:0] v);
    logic [LW-1:0] idx;
    idx = '0;
    for (int i = 0; i < W; i++) begin
      if (v[i]) idx = LW'(i);
    end
    return idx;
  endfunction

  assign accept = (state == ACCUM) && bus.in_valid;
  assign last   = accept && (cnt == CW'(NSAMP - 1));
  assign init   = bus.start && ((state == IDLE) || (state == DONE));

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake/status outputs
  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    bus.done     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = ACCUM;
      end
      ACCUM: begin
        bus.in_ready = 1'b1;
        if (last) state_nxt = RESOLVE;
      end
      RESOLVE: begin
        state_nxt = DONE;
      end
      DONE: begin
        bus.done = 1'b1;
        if (bus.start) state_nxt = ACCUM;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Evidence accumulation; start re-arms the flags, a handshake folds in a sample
  always_ff @(posedge clk) begin
    if (!reset) begin
      diff    <= '0;
      sa0_ok  <= '0;
      sa1_ok  <= '0;
      flip_ok <= '0;
      seen0   <= '0;
      seen1   <= '0;
      cnt     <= '0;
    end else if (init) begin
      diff    <= '0;
      sa0_ok  <= '1;
      sa1_ok  <= '1;
      flip_ok <= '1;
      seen0   <= '0;
      seen1   <= '0;
      cnt     <= '0;
    end else if (accept) begin
      diff    <= diff    | (bus.exp_data ^ bus.obs_data);
      sa0_ok  <= sa0_ok  & ~bus.obs_data;
      sa1_ok  <= sa1_ok  & bus.obs_data;
      flip_ok <= flip_ok & (bus.exp_data ^ bus.obs_data);
      seen0   <= seen0   | ~bus.exp_data;
      seen1   <= seen1   | bus.exp_data;
      cnt     <= cnt + CW'(1);
    end
  end

  // Verdict decode from the accumulated evidence; a flip needs both polarities seen
  always_comb begin
    loc_nxt  = '0;
    type_nxt = 2'b00;
    amb_nxt  = 1'b0;
    if (diff == '0) begin
      amb_nxt = 1'b0;
    end else if ((diff & (diff - W'(1))) == '0) begin
      loc_nxt = bit_index(diff);
      if (flip_ok[loc_nxt] && seen0[loc_nxt] && seen1[loc_nxt]) type_nxt = 2'b11;
      else if (sa0_ok[loc_nxt])                                 type_nxt = 2'b01;
      else if (sa1_ok[loc_nxt])                                 type_nxt = 2'b10;
      else                                                      amb_nxt  = 1'b1;
    end else begin
      amb_nxt = 1'b1;
    end
  end

  // Verdict register, loaded in the single RESOLVE cycle and held through DONE
  always_ff @(posedge clk) begin
    if (!reset) begin
      f_loc_r  <= '0;
      f_type_r <= 2'b00;
      amb_r    <= 1'b0;
    end else if (state == RESOLVE) begin
      f_loc_r  <= loc_nxt;
      f_type_r <= type_nxt;
      amb_r    <= amb_nxt;
    end
  end

  assign bus.f_loc     = f_loc_r;
  assign bus.f_type    = f_type_r;
  assign bus.ambiguous = amb_r;

`ifdef DIAG_ERRCNT_EN
  logic [7:0] err_cnt;

  // Saturating count of mismatching samples in the current window
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (init) begin
      err_cnt <= '0;
    end else if (accept && (bus.exp_data != bus.obs_data) && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign bus.err_count = err_cnt;
`endif
endmodule
